// File: rtl/mem_wait_responder_if.sv
// mem_wait_responder_if
//   Request/response bundle between a cache-side initiator and the
//   wait-state memory responder.
//   Req     - access request (level), sampled only while the responder is idle
//   We      - 1 = write, 0 = read
//   Addr    - word address
//   WData   - write data
//   WaitCfg - number of wait states (0..3) for this access
//   Ready   - one-cycle completion pulse
//   RData   - read data, valid while Ready is high after a read
//   Busy    - high whenever an access is in progress
interface mem_wait_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              Req;
  logic              We;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic [1:0]        WaitCfg;
  logic              Ready;
  logic [DATA_W-1:0] RData;
  logic              Busy;

  modport master (
    output Req, We, Addr, WData, WaitCfg,
    input  Ready, RData, Busy
  );

  modport slave (
    input  Req, We, Addr, WData, WaitCfg,
    output Ready, RData, Busy
  );
endinterface

// File: rtl/mem_wait_responder.sv
// mem_wait_responder
//   Single-port memory that answers each accepted request after a
//   programmable number of wait states (0..3), then pulses Ready for one
//   cycle. Request fields are captured at acceptance, so the initiator may
//   change or drop them while the access is in flight.
//   Clk   - single clock, all state updates on its rising edge
//   Rst_n - asynchronous active-low reset (memory contents are not reset)
//   bus   - slave side of mem_wait_responder_if (request in, Ready/RData/Busy out)
module mem_wait_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  mem_wait_responder_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              accept;
  logic              commit;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state logic. The memory access happens on the WAIT->RESP edge,
  // which is flagged by 'commit' so the read and write paths share it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          accept  = 1'b1;
          cnt_d   = bus.WaitCfg;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, wait counter, captured request and read-data register.
  // Asynchronous reset drops any in-flight access before it can commit.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.We;
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
      end
      if (commit && !we_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // Memory array has no reset; a write only lands on the commit edge, so a
  // reset during WAIT leaves the addressed word untouched.
  always_ff @(posedge Clk) begin
    if (commit && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.Ready = (state_q == RESP);
  assign bus.Busy  = (state_q != IDLE);
  assign bus.RData = rdata_q;

endmodule
